// File: rtl/xcore_if_gshare_ctrl.sv
// G-share front end: hashes fetch PC with speculative history into the counter table index,
// tracks in-flight predictions in order, and commits counter updates / history repair at write-back.
module xcore_if_gshare_ctrl #(
    parameter int GHR_W      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_if_valid,
    input  logic [31:0]      i_if_pc,
    output logic             o_if_ready,
    output logic [GHR_W-1:0] o_bpu_addr,
    input  logic [1:0]       i_bim_bits,
    output logic             o_pred_taken,
    input  logic             i_wb_valid,
    input  logic             i_wb_taken,
    output logic             o_cmt_req,
    output logic             o_cmt_ghr,
    output logic [GHR_W-1:0] o_cmt_addr,
    output logic [1:0]       o_cmt_bits,
    output logic             o_mispredict
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [GHR_W-1:0] idx;
        logic [1:0]       bits;
        logic             pred;
    } entry_t;

    entry_t           fifo [FIFO_DEPTH];
    entry_t           head;
    logic [PW:0]      wr_ptr, rd_ptr;
    logic [GHR_W-1:0] spec_ghr, arch_ghr;
    logic             empty, full, pop, mis, push;
    logic [1:0]       new_bits;
    logic             unused_pc;

    assign unused_pc = ^{i_if_pc[31:GHR_W+2], i_if_pc[1:0]};

    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = ((wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}});
        head         = fifo[rd_ptr[PW-1:0]];
        pop          = i_wb_valid & ~empty;
        mis          = pop & (head.pred != i_wb_taken);
        o_if_ready   = ~full & ~mis;
        push         = i_if_valid & o_if_ready;
        o_bpu_addr   = i_if_pc[GHR_W+1:2] ^ spec_ghr;
        o_pred_taken = i_bim_bits[1];
        new_bits     = head.bits;
        if (i_wb_taken) begin
            if (head.bits != 2'b11) new_bits = head.bits + 2'b01;
        end else begin
            if (head.bits != 2'b00) new_bits = head.bits - 2'b01;
        end
    end

    // Payload storage carries no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge i_sys_clk) begin
        if (push) fifo[wr_ptr[PW-1:0]] <= '{idx: o_bpu_addr, bits: i_bim_bits, pred: o_pred_taken};
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            spec_ghr     <= '0;
            arch_ghr     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_cmt_req    <= 1'b0;
            o_cmt_ghr    <= 1'b0;
            o_cmt_addr   <= '0;
            o_cmt_bits   <= '0;
            o_mispredict <= 1'b0;
        end else begin
            o_cmt_req    <= pop;
            o_mispredict <= mis;
            if (pop) begin
                o_cmt_ghr  <= mis;
                o_cmt_addr <= head.idx;
                o_cmt_bits <= new_bits;
                arch_ghr   <= {arch_ghr[GHR_W-2:0], i_wb_taken};
                rd_ptr     <= rd_ptr + 1'b1;
            end
            // A mispredict flushes every younger entry and rebuilds history from the committed path.
            if (mis) begin
                spec_ghr <= {arch_ghr[GHR_W-2:0], i_wb_taken};
                wr_ptr   <= rd_ptr + 1'b1;
            end else if (push) begin
                spec_ghr <= {spec_ghr[GHR_W-2:0], o_pred_taken};
                wr_ptr   <= wr_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xcore_if_gshare_ctrl.sv
// Scoreboard bench for xcore_if_gshare_ctrl: a queue-based reference model predicts
// each cycle's commit outputs; a separate monitor compares them one cycle later.
module tb_xcore_if_gshare_ctrl;
    localparam int GHR_W = 10;
    localparam int DEPTH = 8;
    localparam int MASK  = (1 << GHR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             if_valid = 1'b0;
    logic [31:0]      if_pc = '0;
    logic             if_ready;
    logic [GHR_W-1:0] bpu_addr;
    logic [1:0]       bim_bits = '0;
    logic             pred_taken;
    logic             wb_valid = 1'b0;
    logic             wb_taken = 1'b0;
    logic             cmt_req, cmt_ghr, mispredict;
    logic [GHR_W-1:0] cmt_addr;
    logic [1:0]       cmt_bits;

    xcore_if_gshare_ctrl #(.GHR_W(GHR_W), .FIFO_DEPTH(DEPTH)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_if_valid(if_valid), .i_if_pc(if_pc), .o_if_ready(if_ready),
        .o_bpu_addr(bpu_addr), .i_bim_bits(bim_bits), .o_pred_taken(pred_taken),
        .i_wb_valid(wb_valid), .i_wb_taken(wb_taken),
        .o_cmt_req(cmt_req), .o_cmt_ghr(cmt_ghr), .o_cmt_addr(cmt_addr),
        .o_cmt_bits(cmt_bits), .o_mispredict(mispredict)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int bits; int pred; } ment_t;
    typedef struct { int req; int ghr; int addr; int bits; int misp; } exp_t;

    ment_t mq[$];
    exp_t  expq[$];
    int    spec_ghr = 0, arch_ghr = 0;
    int    checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, issued at the falling edge; model predicts same-cycle and next-cycle outputs.
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [1:0] bits,
                         input bit wv, input bit wt);
        int    pop, mis, ready, addr, pred, nb;
        ment_t h;
        exp_t  e;
        @(negedge clk);
        if_valid = v; if_pc = pc; bim_bits = bits; wb_valid = wv; wb_taken = wt;
        #1;
        pop   = (wv && mq.size() > 0) ? 1 : 0;
        if (pop) h = mq[0];
        mis   = (pop && h.pred != int'(wt)) ? 1 : 0;
        ready = (mq.size() < DEPTH && !mis) ? 1 : 0;
        addr  = ((pc >> 2) & MASK) ^ spec_ghr;
        pred  = bits[1];
        chk("if_ready", int'(if_ready), ready);
        chk("bpu_addr", int'(bpu_addr), addr);
        chk("pred_taken", int'(pred_taken), pred);
        e = '{req: pop, ghr: mis, addr: 0, bits: 0, misp: mis};
        if (pop) begin
            nb = wt ? ((h.bits < 3) ? h.bits + 1 : 3) : ((h.bits > 0) ? h.bits - 1 : 0);
            e.addr = h.idx; e.bits = nb;
            void'(mq.pop_front());
            if (mis) begin
                spec_ghr = ((arch_ghr << 1) | int'(wt)) & MASK;
                mq.delete();
            end
            arch_ghr = ((arch_ghr << 1) | int'(wt)) & MASK;
        end
        if (v && ready) begin
            mq.push_back('{idx: addr, bits: int'(bits), pred: pred});
            spec_ghr = ((spec_ghr << 1) | pred) & MASK;
        end
        expq.push_back(e);
    endtask

    // Reset asserted between edges: registered outputs must clear without waiting for a clock.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        if_valid = 0; wb_valid = 0; if_pc = 32'h0000_0100; bim_bits = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_cmt_req", int'(cmt_req), 0);
        chk("rst_cmt_ghr", int'(cmt_ghr), 0);
        chk("rst_cmt_addr", int'(cmt_addr), 0);
        chk("rst_cmt_bits", int'(cmt_bits), 0);
        chk("rst_mispredict", int'(mispredict), 0);
        chk("rst_if_ready", int'(if_ready), 1);
        chk("rst_bpu_addr", int'(bpu_addr), 'h040);
        mq.delete(); spec_ghr = 0; arch_ghr = 0;
        e = '{req: 0, ghr: 0, addr: 0, bits: 0, misp: 0};
        expq.push_back(e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one expectation per cycle, compared just after the rising edge that registers it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("cmt_req", int'(cmt_req), e.req);
                chk("mispredict", int'(mispredict), e.misp);
                if (e.req) begin
                    chk("cmt_ghr", int'(cmt_ghr), e.ghr);
                    chk("cmt_addr", int'(cmt_addr), e.addr);
                    chk("cmt_bits", int'(cmt_bits), e.bits);
                end
            end else begin
                chk("cmt_req_unexpected", int'(cmt_req), 0);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        bit          wt;
        do_reset();
        // first prediction after reset, then correct commits with saturation
        cycle(1, 32'h0000_0100, 2'b10, 0, 0);
        cycle(0, 32'h0, 2'b00, 1, 1);
        cycle(1, 32'h0000_0200, 2'b11, 0, 0);
        cycle(0, 32'h0, 2'b00, 1, 1);
        // three predictions (1,1,0), oldest resolves not-taken while fetch also requests
        cycle(1, 32'h0000_1004, 2'b10, 0, 0);
        cycle(1, 32'h0000_2008, 2'b11, 0, 0);
        cycle(1, 32'h0000_300c, 2'b01, 0, 0);
        cycle(1, 32'h0000_4010, 2'b10, 1, 0);
        cycle(1, 32'h0000_0000, 2'b00, 0, 0);
        cycle(0, 32'h0, 2'b00, 1, 0);
        // write-back on empty FIFO is ignored
        cycle(0, 32'h0, 2'b00, 1, 1);
        // fill to full, one extra request, then pop while full
        for (int i = 0; i < 9; i++) cycle(1, 32'h100 + 32'(i * 4), 2'b11, 0, 0);
        cycle(1, 32'h400, 2'b11, 1, 1);
        cycle(1, 32'h404, 2'b11, 0, 0);
        // 24 push/pop pairs to walk pointers through wrap
        for (int i = 0; i < 24; i++) cycle(1, 32'(i * 36), 2'b10, 1, 1);
        for (int i = 0; i < 10; i++) cycle(0, 32'h0, 2'b00, 1, 1);
        // four entries in flight, async reset, then a write-back that must be ignored
        for (int i = 0; i < 4; i++) cycle(1, 32'h800 + 32'(i * 4), 2'b10, 0, 0);
        do_reset();
        cycle(0, 32'h0, 2'b00, 1, 1);
        // randomized traffic, mostly correct predictions so the FIFO fills and drains
        for (int i = 0; i < 800; i++) begin
            pc = $urandom;
            if (mq.size() > 0)
                wt = ($urandom_range(0, 4) == 0) ? !mq[0].pred[0] : mq[0].pred[0];
            else
                wt = $urandom_range(0, 1);
            cycle($urandom_range(0, 3) != 0, pc, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, wt);
        end
        cycle(0, 32'h0, 2'b00, 0, 0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xcore_if_gshare_ctrl.md
# xcore_if_gshare_ctrl

G-share front-end controller that sits directly upstream of the 1024-entry bimodal counter table in the Xcore fetch stage. It hashes the fetch PC with a speculative global history register (GHR) to form the table read index, and turns the 2-bit counter read back into a taken/not-taken prediction. It keeps every in-flight prediction in an in-order FIFO. At write-back it pops the oldest entry, computes the saturated counter update, drives the table's commit write port, and repairs the speculative GHR on a misprediction.

## Interface
Parameters:
- GHR_W, 10, history and index width; index = 2^GHR_W table entries.
- FIFO_DEPTH, 8, number of in-flight predictions (power of two).

Ports:
- i_sys_clk  in  1  system clock; all state updates on the rising edge.
- i_sys_rst  in  1  asynchronous, active-high reset.
- i_if_valid  in  1  fetch presents a conditional branch for prediction.
- i_if_pc  in  32  PC of that branch.
- o_if_ready  out  1  prediction can be accepted this cycle.
- o_bpu_addr  out  GHR_W  table read index = i_if_pc[GHR_W+1:2] ^ spec_ghr (combinational).
- i_bim_bits  in  2  counter read from the table at o_bpu_addr (same-cycle asynchronous read).
- o_pred_taken  out  1  = i_bim_bits[1] (combinational).
- i_wb_valid  in  1  the oldest in-flight branch resolves this cycle.
- i_wb_taken  in  1  its actual direction.
- o_cmt_req  out  1  table update request (registered).
- o_cmt_ghr  out  1  1 = update caused by a mispredict, 0 = correct prediction (registered).
- o_cmt_addr  out  GHR_W  table write index (registered).
- o_cmt_bits  out  2  new counter value (registered).
- o_mispredict  out  1  one-cycle pulse; fetch must redirect (registered).

## Operation
- State:
  - spec_ghr (GHR_W), arch_ghr (GHR_W).
  - FIFO of {idx[GHR_W-1:0], bits[1:0], pred}.
  - wr_ptr and rd_ptr, each log2(FIFO_DEPTH)+1 bits with a wrap bit.
- full = pointers differ only in the wrap bit. empty = pointers equal.
- pop = i_wb_valid & !empty. A write-back with an empty FIFO is ignored: no output, no state change.
- mis = pop & (head.pred != i_wb_taken) (combinational).
- o_if_ready = !full & !mis.
- push = i_if_valid & o_if_ready. On push:
  - write {o_bpu_addr, i_bim_bits, o_pred_taken} at wr_ptr.
  - spec_ghr <= {spec_ghr[GHR_W-2:0], o_pred_taken}.
- On pop:
  - arch_ghr <= {arch_ghr[GHR_W-2:0], i_wb_taken}.
  - Counter update: taken -> min(bits+1, 3); not taken -> max(bits-1, 0). 3 and 0 saturate.
  - Register o_cmt_req=1, o_cmt_addr=head.idx, o_cmt_bits=new counter, o_cmt_ghr=mis.
  - rd_ptr increments, wrapping naturally.
- On mis, at the same edge:
  - spec_ghr <= {arch_ghr[GHR_W-2:0], i_wb_taken}.
  - wr_ptr <= rd_ptr+1, so all younger wrong-path entries are discarded.
  - o_mispredict <= 1.
- Simultaneous push and non-mispredict pop: both take effect. Full with a pop in the same cycle: still not ready (ready depends on current full only).
- Simultaneous push and mis: push is blocked by o_if_ready=0.
- Stale table read: a read of an index being written the same cycle returns the old value; this is accepted.

## Timing
- Reset (async, immediate) clears: spec_ghr=0, arch_ghr=0, both pointers=0, o_cmt_req=0, o_cmt_ghr=0, o_cmt_addr=0, o_cmt_bits=0, o_mispredict=0. o_if_ready=1 after reset.
- Reset mid-operation drops all in-flight entries; no commit output follows.
- o_bpu_addr, o_pred_taken and o_if_ready are combinational and valid in the same cycle as the request.
- Commit latency: i_wb_valid in cycle N -> o_cmt_* and o_mispredict in cycle N+1. All commit outputs are held valid for exactly one cycle; o_cmt_req=0 otherwise.
- Recovered spec_ghr is used for o_bpu_addr from cycle N+1.
- Back-to-back pops every cycle are supported; throughput is one prediction plus one commit per cycle.

## Test plan
- Reset, then PC=0x0000_0100 with spec_ghr=0 -> o_bpu_addr=0x040. With i_bim_bits=2'b10 -> o_pred_taken=1 and spec_ghr=0x001 after the edge.
- Correct commit: entry bits=2'b10 predicted taken, wb taken -> next cycle o_cmt_req=1, o_cmt_ghr=0, o_cmt_bits=2'b11. Repeat at bits=2'b11 -> stays 2'b11 (saturation).
- Mispredict: push 3 branches (pred 1,1,0), wb oldest not taken with bits=2'b10 -> o_mispredict=1, o_cmt_ghr=1, o_cmt_bits=2'b01, FIFO empty, spec_ghr=arch_ghr shifted with 0.
- Full: 8 pushes without commit -> o_if_ready=0, 9th i_if_valid not stored. One pop -> ready next cycle; pointer wrap verified over 20+ push/pop pairs.
- Edge cases: i_wb_valid with empty FIFO -> no o_cmt_req. i_if_valid in the same cycle as a mispredicting wb -> not accepted.
- Async reset asserted between clock edges with 4 entries in flight -> all outputs 0 immediately; first post-reset commit with an empty FIFO is ignored.
